// File: rtl/lsu_pkg.sv
// Shared definitions for the misalignment-splitting load/store unit:
// RV32I funct3 encodings, the controller state type and request classifiers.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        StIdle,
        StSplit,
        StResp
    } lsu_state_e;

    function automatic logic is_legal(input logic we, input logic [2:0] func3);
        if (we) begin
            return (func3 == SB) || (func3 == SH) || (func3 == SW);
        end
        return (func3 == LB) || (func3 == LH) || (func3 == LW) ||
               (func3 == LBU) || (func3 == LHU);
    endfunction

    // Only halves and words can be misaligned; byte accesses never are.
    function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
        return ((func3[1:0] == 2'b01) && addr_lo[0]) ||
               ((func3[1:0] == 2'b10) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_ext.sv
// Combinational load-data extender: applies funct3 sign/zero extension to
// little-endian assembled bytes.
module lsu_ext
    import lsu_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  func3_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = '0;
        case (func3_i)
            LB:      data_o = {{24{data_i[7]}}, data_i[7:0]};
            LH:      data_o = {{16{data_i[15]}}, data_i[15:0]};
            LW:      data_o = data_i;
            LBU:     data_o = {24'b0, data_i[7:0]};
            LHU:     data_o = {16'b0, data_i[15:0]};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_misalign.sv
// Load/store unit front end: passes aligned accesses straight to the data RAM
// and either splits misaligned half/word accesses into byte accesses or rejects them.
module lsu_misalign
    import lsu_pkg::*;
#(
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_func3_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [2:0]  mem_func3_o,
    input  logic [31:0] mem_rdata_i
);

    lsu_state_e  state_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  func3_q;
    logic [1:0]  idx_q;
    logic [1:0]  last_q;
    logic [31:0] asm_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        legal;
    logic        misal;
    logic        err_go;
    logic        split_go;
    logic [31:0] asm_d;
    logic [7:0]  wbyte;
    logic [31:0] ext_data;

    assign legal    = is_legal(req_we_i, req_func3_i);
    assign misal    = is_misaligned(req_func3_i, req_addr_i[1:0]);
    assign err_go   = !legal || (misal && !MISALIGN_EN);
    assign split_go = legal && misal && MISALIGN_EN;
    assign wbyte    = wdata_q[8*idx_q +: 8];

    always_comb begin
        asm_d = asm_q;
        asm_d[8*idx_q +: 8] = mem_rdata_i[7:0];
    end

    // Extension sees the final byte in the same cycle it is captured.
    lsu_ext u_ext (
        .data_i  (asm_d),
        .func3_i (func3_q),
        .data_o  (ext_data)
    );

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = req_addr_i;
        mem_wdata_o = req_wdata_i;
        mem_func3_o = req_func3_i;
        unique case (state_q)
            StIdle: begin
                mem_we_o = req_valid_i && legal && !misal && req_we_i;
            end
            StSplit: begin
                mem_addr_o  = addr_q + {30'b0, idx_q};
                mem_wdata_o = {24'b0, wbyte};
                mem_func3_o = we_q ? SB : LBU;
                mem_we_o    = we_q;
            end
            default: ;
        endcase
        // Reset is sampled at the edge, so the RAM must not write in that same cycle.
        if (reset_i) begin
            mem_we_o = 1'b0;
        end
    end

    assign req_ready_o  = (state_q == StIdle);
    assign resp_valid_o = (state_q == StResp);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            func3_q <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            asm_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        we_q    <= req_we_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        func3_q <= req_func3_i;
                        idx_q   <= '0;
                        asm_q   <= '0;
                        last_q  <= (req_func3_i[1:0] == 2'b10) ? 2'd3 : 2'd1;
                        if (err_go) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            state_q <= StResp;
                        end else if (split_go) begin
                            err_q   <= 1'b0;
                            state_q <= StSplit;
                        end else begin
                            rdata_q <= req_we_i ? 32'b0 : mem_rdata_i;
                            err_q   <= 1'b0;
                            state_q <= StResp;
                        end
                    end
                end
                StSplit: begin
                    if (!we_q) begin
                        asm_q <= asm_d;
                    end
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == last_q) begin
                        idx_q   <= '0;
                        rdata_q <= we_q ? 32'b0 : ext_data;
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_misalign.sv
// Self-checking bench: byte-array RAM model per DUT, scoreboard of expected
// responses and latencies for the splitting instance, inline checks elsewhere.
module tb_lsu_misalign;
    import lsu_pkg::*;

    logic clk;
    logic reset;

    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_func3;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_func3;

    logic        req_valid1, req_ready1, req_we1;
    logic [31:0] req_addr1, req_wdata1;
    logic [2:0]  req_func3_1;
    logic        resp_valid1, resp_err1;
    logic [31:0] resp_rdata1;
    logic        mem_we1;
    logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;
    logic [2:0]  mem_func3_1;

    logic [7:0] ram0 [256] = '{default: 8'h00};
    logic [7:0] ram1 [256] = '{default: 8'h00};
    wire  [7:0] a0 = mem_addr[7:0];
    wire  [7:0] a1 = mem_addr1[7:0];

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   we0_seen = 0;
    int   we1_seen = 0;

    lsu_misalign #(.MISALIGN_EN(1'b1)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_func3_i  (req_func3),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_func3_o  (mem_func3),
        .mem_rdata_i  (mem_rdata)
    );

    lsu_misalign #(.MISALIGN_EN(1'b0)) dut_nm (
        .clk_i        (clk),
        .reset_i      (reset),
        .req_valid_i  (req_valid1),
        .req_ready_o  (req_ready1),
        .req_we_i     (req_we1),
        .req_addr_i   (req_addr1),
        .req_wdata_i  (req_wdata1),
        .req_func3_i  (req_func3_1),
        .resp_valid_o (resp_valid1),
        .resp_rdata_o (resp_rdata1),
        .resp_err_o   (resp_err1),
        .mem_we_o     (mem_we1),
        .mem_addr_o   (mem_addr1),
        .mem_wdata_o  (mem_wdata1),
        .mem_func3_o  (mem_func3_1),
        .mem_rdata_i  (mem_rdata1)
    );

    function automatic logic [31:0] rd_ext(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3,
                                           input logic [2:0] f3);
        case (f3)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b010:  return {b3, b2, b1, b0};
            3'b100:  return {24'b0, b0};
            3'b101:  return {16'b0, b1, b0};
            default: return 32'b0;
        endcase
    endfunction

    assign mem_rdata  = rd_ext(ram0[a0], ram0[a0 + 8'd1], ram0[a0 + 8'd2], ram0[a0 + 8'd3],
                               mem_func3);
    assign mem_rdata1 = rd_ext(ram1[a1], ram1[a1 + 8'd1], ram1[a1 + 8'd2], ram1[a1 + 8'd3],
                               mem_func3_1);

    always @(posedge clk) begin
        if (mem_we) begin
            ram0[a0] <= mem_wdata[7:0];
            if (mem_func3[1:0] != 2'b00) ram0[a0 + 8'd1] <= mem_wdata[15:8];
            if (mem_func3[1:0] == 2'b10) begin
                ram0[a0 + 8'd2] <= mem_wdata[23:16];
                ram0[a0 + 8'd3] <= mem_wdata[31:24];
            end
        end
        if (mem_we1) begin
            ram1[a1] <= mem_wdata1[7:0];
            if (mem_func3_1[1:0] != 2'b00) ram1[a1 + 8'd1] <= mem_wdata1[15:8];
            if (mem_func3_1[1:0] == 2'b10) begin
                ram1[a1 + 8'd2] <= mem_wdata1[23:16];
                ram1[a1 + 8'd3] <= mem_wdata1[31:24];
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: pairs each response with the oldest expectation and acceptance cycle.
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (mem_we)  we0_seen <= we0_seen + 1;
        if (mem_we1) we1_seen <= we1_seen + 1;
        if (!reset) begin
            if (req_valid && req_ready) acc_q.push_back(cyc);
            if (resp_valid) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d, required none",
                             cyc);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    n_cmp++;
                    if (resp_rdata !== e.rd) begin
                        n_bad++;
                        $display("FAIL resp_rdata: got %h required %h", resp_rdata, e.rd);
                    end
                    n_cmp++;
                    if (resp_err !== e.err) begin
                        n_bad++;
                        $display("FAIL resp_err: got %b required %b", resp_err, e.err);
                    end
                    n_cmp++;
                    if (cyc - a !== e.lat) begin
                        n_bad++;
                        $display("FAIL latency: got %0d required %0d", cyc - a, e.lat);
                    end
                end
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_err,
                          input int lat, output int acc);
        exp_t e;
        e.rd = exp_rd; e.err = exp_err; e.lat = lat;
        @(posedge clk); #1;
        exp_q.push_back(e);
        req_we = we; req_addr = addr; req_wdata = wd; req_func3 = f3; req_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 40 && acc < 0; i++) begin
            @(negedge clk);
            if (req_ready) acc = cyc;
        end
        if (acc < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got no accept in 40 cycles, required accept");
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int i;
        for (i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL resp_timeout: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++;
            $display("FAIL reset_ready: got %b required 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++;
            $display("FAIL reset_valid: got %b required 0", resp_valid); end
        n_cmp++; if (resp_err !== 1'b0) begin n_bad++;
            $display("FAIL reset_err: got %b required 0", resp_err); end
        n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++;
            $display("FAIL reset_rdata: got %h required 0", resp_rdata); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++;
            $display("FAIL reset_mem_we: got %b required 0", mem_we); end
    endtask

    task automatic test_aligned();
        int acc;
        do_req(1'b1, 32'h08, 32'h1234_5678, SW, 32'h0, 1'b0, 1, acc);
        wait_resp();
        do_req(1'b0, 32'h08, 32'h0, LW, 32'h1234_5678, 1'b0, 1, acc);
        wait_resp();
    endtask

    task automatic test_split_store();
        int          acc;
        logic [31:0] wd;
        wd = 32'hAABB_CCDD;
        do_req(1'b1, 32'h05, wd, SW, 32'h0, 1'b0, 5, acc);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (mem_we !== 1'b1 || mem_addr !== 32'h05 + k || mem_func3 !== SB ||
                mem_wdata[7:0] !== wd[8*k +: 8]) begin
                n_bad++;
                $display("FAIL split_byte%0d: got we=%b addr=%h f3=%b byte=%h required 1 %h 000 %h",
                         k, mem_we, mem_addr, mem_func3, mem_wdata[7:0], 32'h05 + k, wd[8*k +: 8]);
            end
        end
        wait_resp();
        do_req(1'b0, 32'h05, 32'h0, LW, wd, 1'b0, 5, acc);
        wait_resp();
    endtask

    task automatic test_reset_split();
        int acc;
        do_req(1'b1, 32'h03, 32'h5A, SB, 32'h0, 1'b0, 1, acc);
        wait_resp();
        do_req(1'b1, 32'h04, 32'h5A, SB, 32'h0, 1'b0, 1, acc);
        wait_resp();
        do_req(1'b1, 32'h01, 32'hA1B2_C3D4, SW, 32'h0, 1'b0, 5, acc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++;
            $display("FAIL rst_split_ready: got %b required 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++;
            $display("FAIL rst_split_valid: got %b required 0", resp_valid); end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (ram0[1] !== 8'hD4 || ram0[2] !== 8'hC3 || ram0[3] !== 8'h5A || ram0[4] !== 8'h5A) begin
            n_bad++;
            $display("FAIL rst_split_ram: got %h %h %h %h required d4 c3 5a 5a",
                     ram0[1], ram0[2], ram0[3], ram0[4]);
        end
    endtask

    task automatic test_half_load();
        int acc;
        do_req(1'b1, 32'h03, 32'h80, SB, 32'h0, 1'b0, 1, acc);
        wait_resp();
        do_req(1'b1, 32'h04, 32'hFF, SB, 32'h0, 1'b0, 1, acc);
        wait_resp();
        do_req(1'b0, 32'h03, 32'h0, LH, 32'hFFFF_FF80, 1'b0, 3, acc);
        wait_resp();
        do_req(1'b0, 32'h03, 32'h0, LHU, 32'h0000_FF80, 1'b0, 3, acc);
        wait_resp();
        do_req(1'b0, 32'h03, 32'h0, LB, 32'hFFFF_FF80, 1'b0, 1, acc);
        wait_resp();
    endtask

    task automatic test_wrap();
        int acc;
        do_req(1'b1, 32'hFFFF_FFFF, 32'h1122_3344, SW, 32'h0, 1'b0, 5, acc);
        wait_resp();
        n_cmp++;
        if (ram0[255] !== 8'h44 || ram0[0] !== 8'h33 || ram0[1] !== 8'h22 || ram0[2] !== 8'h11)
        begin
            n_bad++;
            $display("FAIL wrap_ram: got %h %h %h %h required 44 33 22 11",
                     ram0[255], ram0[0], ram0[1], ram0[2]);
        end
        do_req(1'b0, 32'hFFFF_FFFF, 32'h0, LW, 32'h1122_3344, 1'b0, 5, acc);
        wait_resp();
    endtask

    task automatic test_illegal();
        int acc;
        int s;
        s = we0_seen;
        do_req(1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1, 1, acc);
        wait_resp();
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b100, 32'h0, 1'b1, 1, acc);
        wait_resp();
        n_cmp++;
        if (we0_seen !== s || ram0[16] !== 8'h00) begin
            n_bad++;
            $display("FAIL illegal_no_write: got we_cycles=%0d ram=%h required 0 00",
                     we0_seen - s, ram0[16]);
        end
    endtask

    task automatic req1(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, input logic exp_err);
        int acc;
        @(posedge clk); #1;
        req_we1 = we; req_addr1 = addr; req_wdata1 = wd; req_func3_1 = f3; req_valid1 = 1'b1;
        acc = -1;
        for (int i = 0; i < 40 && acc < 0; i++) begin
            @(negedge clk);
            if (req_ready1) acc = cyc;
        end
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (acc < 0 || resp_valid1 !== 1'b1 || resp_err1 !== exp_err || resp_rdata1 !== 32'h0)
        begin
            n_bad++;
            $display("FAIL nm_resp f3=%b: got acc=%0d valid=%b err=%b rdata=%h required 1 %b 0",
                     f3, acc, resp_valid1, resp_err1, resp_rdata1, exp_err);
        end
    endtask

    task automatic test_no_misalign();
        int s;
        s = we1_seen;
        req1(1'b1, 32'h01, 32'h0000_BEEF, SH, 1'b1);
        req1(1'b0, 32'h02, 32'h0, LW, 1'b1);
        req1(1'b0, 32'h00, 32'h0, 3'b011, 1'b1);
        req1(1'b0, 32'h00, 32'h0, LW, 1'b0);
        n_cmp++;
        if (we1_seen !== s || ram1[1] !== 8'h00 || ram1[2] !== 8'h00) begin
            n_bad++;
            $display("FAIL nm_no_write: got we_cycles=%0d ram=%h %h required 0 00 00",
                     we1_seen - s, ram1[1], ram1[2]);
        end
    endtask

    task automatic test_back_to_back();
        int acc1;
        int acc2;
        do_req(1'b1, 32'h21, 32'h0BAD_F00D, SW, 32'h0, 1'b0, 5, acc1);
        do_req(1'b0, 32'h21, 32'h0, LW, 32'h0BAD_F00D, 1'b0, 5, acc2);
        n_cmp++;
        if (acc2 - acc1 !== 6) begin
            n_bad++;
            $display("FAIL b2b_accept_gap: got %0d required 6", acc2 - acc1);
        end
        wait_resp();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_func3 = '0;
        req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_func3_1 = '0;
        test_reset();
        test_aligned();
        test_split_store();
        test_reset_split();
        test_half_load();
        test_wrap();
        test_illegal();
        test_no_misalign();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_misalign.md
LSU_MISALIGN -- requirements
Module: lsu_misalign

Interface
REQ-001 Parameter MISALIGN_EN, default 1: 1 = split misaligned half/word accesses into byte accesses; 0 = reject them with an error.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock; all state changes on the rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  the CPU presents a request.
REQ-006 req_ready  out  1  the unit accepts a request; a request is accepted on a cycle where req_valid && req_ready.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 req_func3  in  3  RV32I funct3: loads 000/001/010/100/101, stores 000/001/010.
REQ-011 resp_valid  out  1  one-cycle completion pulse for every accepted request.
REQ-012 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  out  1  qualifies resp_valid: illegal func3, or misaligned with MISALIGN_EN=0.
REQ-014 mem_we / mem_addr / mem_wData / mem_func3  out  1/32/32/3  data-RAM port; the RAM writes on the rising edge and applies func3 byte/half/word semantics.
REQ-015 mem_rData  in  32  combinational RAM read data, already extended by the RAM per mem_func3.

Function
REQ-016 States: IDLE, SPLIT, RESP; req_ready = 1 only in IDLE.
REQ-017 Misaligned: func3[1:0]=01 with addr[0]=1, or func3[1:0]=10 with addr[1:0]!=0; all byte accesses are aligned.
REQ-018 Aligned legal request in IDLE: mem_* = req_* combinationally in the accept cycle (mem_we = req_we).
REQ-019 In that same cycle, resp_rdata is registered from mem_rData for loads; the unit enters RESP.
REQ-020 Aligned latency: resp_valid is high exactly one cycle after acceptance.
REQ-021 Misaligned legal request with MISALIGN_EN=1: accept-cycle mem_we=0; addr/wdata/func3/we are latched; N = 2 (half) or 4 (word); byte index k=0; go to SPLIT.
REQ-022 SPLIT cycle k: mem_addr = addr+k (mod 2^32), mem_func3 = 000 for stores or 100 for loads, mem_wData[7:0] = wdata byte k, mem_we = we.
REQ-023 For loads in SPLIT, mem_rData[7:0] is captured into assembly byte k.
REQ-024 After byte N-1 the unit goes to RESP.
REQ-025 Misaligned latency: resp_valid is high N+1 cycles after acceptance.
REQ-026 Load data in RESP: assembled bytes are little-endian; LH sign-extends bit 15; LHU zero-extends; LW takes the full 32 bits.
REQ-027 Error request (illegal func3 for the direction, or misaligned with MISALIGN_EN=0): mem_we=0 throughout, no RAM write; RESP with resp_err=1 and resp_rdata=0.
REQ-028 RESP lasts exactly one cycle and then returns to IDLE; no request is accepted in RESP.
REQ-029 mem_we = 0 in every cycle not issuing a store byte or an aligned store.
REQ-030 req_valid while not in IDLE is ignored; the requester holds its request until accepted.
REQ-031 Address wrap: req_addr 0xFFFF_FFFF word access uses bytes at FFFF_FFFF, 0, 1, 2.

Reset
REQ-032 Reset → IDLE; resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, byte index=0, assembly register=0.
REQ-033 Reset during SPLIT aborts the access with no response; bytes already written stay in RAM.
REQ-034 req_ready is 1 in the first cycle after reset deasserts.

Structure
REQ-035 Package lsu_pkg SHALL hold the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the state enum.
REQ-036 The one sub-module SHALL be lsu_ext, a combinational extender taking assembled data and func3 and producing resp_rdata.

Verification
REQ-037 Aligned SW 0x1234_5678 @0x08, then LW @0x08 → each resp_valid 1 cycle after accept; rdata 0x1234_5678.
REQ-038 SW 0xAABB_CCDD @0x05 → 4 SB cycles at 0x05–0x08 with bytes DD, CC, BB, AA; resp_valid at accept+5; LW @0x05 → 0xAABB_CCDD.
REQ-039 Memory bytes 0x03=0x80, 0x04=0xFF: LH @0x03 → 0xFFFF_FF80; LHU @0x03 → 0x0000_FF80; each with resp_valid at accept+3.
REQ-040 MISALIGN_EN=0: SH @0x01 → resp_err=1 at accept+1, mem_we never high, RAM unchanged; func3=011 load → resp_err=1.
REQ-041 Reset asserted in SPLIT after 2 bytes of SW @0x01 → no resp_valid; only bytes 0x01–0x02 modified; req_ready=1 the cycle after reset drops.
REQ-042 req_valid held high during SPLIT with a second request → second request accepted only in the cycle after RESP, and completes normally.
